rcvr_drain_ctrl: RTL and testbench
==================================

# rcvr_drain_ctrl

Controller that services the serial frame receiver. It watches the receiver's `ready`, captures each received byte into a small FIFO, and pulses `reading` to acknowledge it. It then presents the bytes to a downstream consumer over a valid/pop interface. It also keeps saturating counters of bytes the receiver lost (overrun) and bytes dropped because the FIFO was full.

## Interface
- `DEPTH`, 4: number of FIFO entries; must be a power of 2, at least 2.
- `CW`, 8: width of the drop and overrun counters.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all control state.
- `enable`  in  1  when 0, new bytes are not serviced.
- `rx_ready`  in  1  receiver's `ready` output.
- `rx_overrun`  in  1  receiver's `overrun` output.
- `rx_data`  in  8  receiver's `data_out`.
- `rx_reading`  out  1  drives the receiver's `reading` input.
- `out_valid`  out  1  FIFO not empty.
- `out_data`  out  8  FIFO head byte; 8'h00 when `out_valid`=0.
- `out_pop`  in  1  consumer takes the head byte this cycle; ignored when `out_valid`=0.
- `fifo_count`  out  log2(DEPTH)+1  number of occupied FIFO entries.
- `drop_count`  out  CW  bytes discarded because the FIFO was full; saturating.
- `overrun_count`  out  CW  bytes captured while `rx_overrun`=1; saturating.
- `clear_counts`  in  1  synchronous clear of `drop_count` and `overrun_count`.

## Operation
- Reset (asynchronous):
  - state=IDLE.
  - FIFO pointers and `fifo_count` = 0.
  - `rx_reading`=0, `out_valid`=0, `out_data`=8'h00.
  - Both counters = 0.
  - FIFO storage is not reset.
- FSM, two states:
  - IDLE: if `enable` && `rx_ready`, capture at this edge and go to ACK; otherwise stay in IDLE.
  - ACK: go to IDLE unconditionally. `rx_reading`=1 only in ACK; it is a decode of the state register, glitch-free.
- Capture, at the IDLE→ACK edge:
  - Push `rx_data` if `fifo_count`<DEPTH, or if a pop is accepted in the same cycle.
  - Otherwise discard the byte and increment `drop_count`; the byte is still acknowledged.
  - If `rx_overrun`=1 at the capture edge, increment `overrun_count`.
  - Both increments can happen on the same edge.
- Receiver handshake:
  - The receiver clears `ready` at the end of the ACK cycle.
  - The receiver gives priority to a new byte's set. If a new byte lands at that same edge, `rx_ready` stays 1 and IDLE captures it on the next edge; no byte is lost.
  - `enable` falling while in ACK does not abort the ACK.
- FIFO:
  - Circular buffer, DEPTH entries.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - `fifo_count` tracks push minus pop.
- Pop:
  - Accepted when `out_pop` && `out_valid`; advances the read pointer.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push and pop on an empty FIFO: not possible, because the pop requires `out_valid`.
- Counters:
  - Saturate at 2^CW-1.
  - `clear_counts` has priority over a coincident increment; the result is 0.
- `enable`=0: the receiver keeps its byte. Further arrivals set the receiver's overrun, which is counted on the next capture after `enable` returns.

## Timing
- Receiver sets `rx_ready` at edge E. Then:
  - Capture at E+1.
  - `out_valid` and `out_data` updated after E+1.
  - `rx_reading`=1 during the E+1..E+2 cycle.
  - Receiver `ready` cleared at E+2.
- Per-byte service: 2 cycles. The receiver needs at least 16 cycles per byte, so with `enable`=1 no receiver overrun is caused by this block.
- `out_valid`, `out_data`, `fifo_count`: combinational from registered pointers, count and storage. No combinational path from `out_pop` to `out_valid` or `out_data`.
- `rx_reading`: registered-state decode, no input-to-output path.

## Test plan
- Single byte: receiver delivers 8'h3C, `enable`=1, no pop → `rx_reading` high exactly 1 cycle, 1 cycle after `rx_ready` rises; `out_valid`=1, `out_data`=8'h3C, `fifo_count`=1; receiver `ready` drops.
- Fill and drop, DEPTH=4, no pops:
  - Deliver 8'h01..8'h05 → `fifo_count`=4, `drop_count`=1.
  - Pops then return 01, 02, 03, 04 in order, then `out_valid`=0 and `out_data`=8'h00.
- Full with simultaneous pop: FIFO holds 4 bytes; new byte 8'hAA captured on the same edge as `out_pop` → no drop, `fifo_count` stays 4, last entry 8'hAA.
- Enable gating:
  - `enable`=0 while two bytes arrive → no `rx_reading`.
  - Raise `enable` → second byte captured, `overrun_count`=1, receiver overrun cleared after the ACK.
- Counter saturation and clear, CW=2:
  - Force 5 drops → `drop_count`=3.
  - `clear_counts` asserted on the edge of another drop → `drop_count`=0.
- Reset mid-operation: assert `reset` asynchronously during ACK with 3 bytes queued → `rx_reading`, `out_valid`, `fifo_count` and the counters go to 0 immediately without waiting for a clock edge; after release, the next byte is captured normally as a single entry.

Source files
------------

// File: rtl/rcvr_drain_ctrl.sv
// rcvr_drain_ctrl
// Services a serial frame receiver. When the receiver has a byte ready,
// the byte is captured into a small circular FIFO and acknowledged with a
// one-cycle rx_reading_o pulse. A downstream consumer drains the FIFO over
// a valid/pop interface. Two saturating counters track bytes dropped on a
// full FIFO and bytes captured while the receiver flagged an overrun.
//
// Ports
//   clock_i          single clock, rising edge
//   reset_i          asynchronous active-high reset
//   enable_i         0 = leave new bytes in the receiver
//   rx_ready_i       receiver has a byte
//   rx_overrun_i     receiver lost a byte before this one was read
//   rx_data_i        receiver byte
//   rx_reading_o     acknowledge to the receiver (one cycle per byte)
//   out_valid_o      FIFO not empty
//   out_data_o       FIFO head byte, 8'h00 when empty
//   out_pop_i        consumer takes the head byte
//   fifo_count_o     occupied FIFO entries
//   drop_count_o     bytes discarded on a full FIFO (saturating)
//   overrun_count_o  bytes captured with rx_overrun_i set (saturating)
//   clear_counts_i   synchronous clear of both counters
module rcvr_drain_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     rx_ready_i,
    input  logic                     rx_overrun_i,
    input  logic [7:0]               rx_data_i,
    output logic                     rx_reading_o,
    output logic                     out_valid_o,
    output logic [7:0]               out_data_o,
    input  logic                     out_pop_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic [CW-1:0]            drop_count_o,
    output logic [CW-1:0]            overrun_count_o,
    input  logic                     clear_counts_i
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t          state_q;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [CW-1:0]   drop_q, ovr_q;

    logic capture, pop, push, drop;

    // No capture while acknowledging: the receiver only drops ready at the
    // end of the ACK cycle, so sampling it there would double-capture.
    assign capture = (state_q == IDLE) && enable_i && rx_ready_i;
    assign pop     = out_pop_i && (count_q != '0);
    // A pop on the capture edge frees the slot the push needs.
    assign push    = capture && ((count_q != FULL) || pop);
    assign drop    = capture && !push;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            ovr_q    <= '0;
        end else begin
            case (state_q)
                IDLE:    state_q <= capture ? ACK : IDLE;
                default: state_q <= IDLE;
            endcase

            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase

            if (clear_counts_i)
                drop_q <= '0;
            else if (drop && (drop_q != '1))
                drop_q <= drop_q + CW'(1);

            if (clear_counts_i)
                ovr_q <= '0;
            else if (capture && rx_overrun_i && (ovr_q != '1))
                ovr_q <= ovr_q + CW'(1);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock_i) begin
        if (push) mem_q[wr_ptr_q] <= rx_data_i;
    end

    assign rx_reading_o    = (state_q == ACK);
    assign out_valid_o     = (count_q != '0);
    assign out_data_o      = out_valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count_o    = count_q;
    assign drop_count_o    = drop_q;
    assign overrun_count_o = ovr_q;

endmodule

// File: tb/tb_rcvr_drain_ctrl.sv
module tb_rcvr_drain_ctrl;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic       clock_i = 0, reset_i = 1, enable_i = 0;
    logic       rx_ready_i = 0, rx_overrun_i = 0;
    logic [7:0] rx_data_i = 8'h00;
    logic       out_pop_i = 0, clear_counts_i = 0;
    logic       rx_reading_o, out_valid_o;
    logic [7:0] out_data_o;
    logic [2:0] fifo_count_o;
    logic [CW-1:0] drop_count_o, overrun_count_o;

    rcvr_drain_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .rx_ready_i(rx_ready_i), .rx_overrun_i(rx_overrun_i), .rx_data_i(rx_data_i),
        .rx_reading_o(rx_reading_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_pop_i(out_pop_i), .fifo_count_o(fifo_count_o),
        .drop_count_o(drop_count_o), .overrun_count_o(overrun_count_o),
        .clear_counts_i(clear_counts_i)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0, errors = 0;

    // Reference model: queue of stored bytes, counters as plain integers,
    // and whether the byte captured on the last edge is being acknowledged.
    logic [7:0] m_q[$];
    int  m_drop = 0, m_ovr = 0;
    bit  m_ack = 0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic logic [7:0] m_head();
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
    endfunction

    // One clock: the receiver reacts to the acknowledge, optionally a new
    // byte arrives, inputs are applied and the model predicts the edge.
    // Returns #1 after the rising edge.
    task automatic step(input bit arrive, input logic [7:0] b, input bit pop,
                        input bit en, input bit clr);
        bit cap;
        @(negedge clock_i);
        if (rx_reading_o) begin rx_ready_i = 0; rx_overrun_i = 0; end
        if (arrive) begin
            if (rx_ready_i) rx_overrun_i = 1;
            rx_ready_i = 1;
            rx_data_i  = b;
        end
        enable_i = en; out_pop_i = pop; clear_counts_i = clr;
        cap = en && rx_ready_i && !m_ack;
        if (pop && m_q.size() != 0) void'(m_q.pop_front());
        if (cap) begin
            if (m_q.size() < DEPTH) m_q.push_back(rx_data_i);
            else m_drop = sat(m_drop + 1);
            if (rx_overrun_i) m_ovr = sat(m_ovr + 1);
        end
        if (clr) begin m_drop = 0; m_ovr = 0; end
        m_ack = cap;
        @(posedge clock_i); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && m_q.size() != 0; i++) step(0, 8'h00, 1, 1, 0);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (rx_reading_o !== 1'b0) begin errors++; $display("FAIL reset_reading got %b exp 0", rx_reading_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid_o); end
        checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data_o); end
        checks++; if (fifo_count_o !== 3'd0 || drop_count_o !== '0 || overrun_count_o !== '0) begin
            errors++; $display("FAIL reset_counts got %0d/%0d/%0d exp 0/0/0", fifo_count_o, drop_count_o, overrun_count_o); end
        @(negedge clock_i); reset_i = 0;
    endtask

    task automatic test_single();
        step(1, 8'h3C, 0, 1, 0);
        checks++; if (rx_reading_o !== 1'b1) begin errors++; $display("FAIL single_reading_on got %b exp 1", rx_reading_o); end
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h3C) begin
            errors++; $display("FAIL single_data got %b/%h exp 1/3c", out_valid_o, out_data_o); end
        checks++; if (fifo_count_o !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", fifo_count_o); end
        step(0, 8'h00, 0, 1, 0);
        checks++; if (rx_reading_o !== 1'b0) begin errors++; $display("FAIL single_reading_off got %b exp 0", rx_reading_o); end
        idle(2);
        checks++; if (fifo_count_o !== 3'd1) begin errors++; $display("FAIL single_no_recapture got %0d exp 1", fifo_count_o); end
        drain();
    endtask

    task automatic test_fill_drop();
        for (int i = 1; i <= 5; i++) begin step(1, 8'(i), 0, 1, 0); idle(3); end
        checks++; if (fifo_count_o !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", fifo_count_o); end
        checks++; if (drop_count_o !== 2'd1) begin errors++; $display("FAIL fill_drop got %0d exp 1", drop_count_o); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_data_o !== 8'(i)) begin errors++; $display("FAIL fill_order got %h exp %h", out_data_o, 8'(i)); end
            step(0, 8'h00, 1, 1, 0);
        end
        checks++; if (out_valid_o !== 1'b0 || out_data_o !== 8'h00) begin
            errors++; $display("FAIL fill_empty got %b/%h exp 0/00", out_valid_o, out_data_o); end
    endtask

    task automatic test_full_pop();
        int d0;
        for (int i = 0; i < 4; i++) begin step(1, 8'h10 + 8'(i), 0, 1, 0); idle(2); end
        d0 = m_drop;
        step(1, 8'hAA, 1, 1, 0);
        checks++; if (fifo_count_o !== 3'd4) begin errors++; $display("FAIL fullpop_count got %0d exp 4", fifo_count_o); end
        checks++; if (drop_count_o !== 2'(d0)) begin errors++; $display("FAIL fullpop_drop got %0d exp %0d", drop_count_o, d0); end
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1, 0);
        checks++; if (out_data_o !== 8'hAA) begin errors++; $display("FAIL fullpop_last got %h exp aa", out_data_o); end
        drain();
    endtask

    task automatic test_enable();
        step(0, 8'h00, 0, 1, 1);
        step(1, 8'h11, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        checks++; if (rx_reading_o !== 1'b0 || fifo_count_o !== 3'd0) begin
            errors++; $display("FAIL enable_gated got %b/%0d exp 0/0", rx_reading_o, fifo_count_o); end
        step(0, 8'h00, 0, 1, 0);
        checks++; if (rx_reading_o !== 1'b1 || out_data_o !== 8'h22) begin
            errors++; $display("FAIL enable_capture got %b/%h exp 1/22", rx_reading_o, out_data_o); end
        checks++; if (overrun_count_o !== 2'd1) begin errors++; $display("FAIL enable_overrun got %0d exp 1", overrun_count_o); end
        idle(3);
        checks++; if (fifo_count_o !== 3'd1 || overrun_count_o !== 2'd1) begin
            errors++; $display("FAIL enable_after got %0d/%0d exp 1/1", fifo_count_o, overrun_count_o); end
        drain();
    endtask

    task automatic test_saturate();
        step(0, 8'h00, 0, 1, 1);
        for (int i = 0; i < 9; i++) begin step(1, 8'h40 + 8'(i), 0, 1, 0); idle(1); end
        checks++; if (drop_count_o !== 2'd3) begin errors++; $display("FAIL sat_drop got %0d exp 3", drop_count_o); end
        step(1, 8'h55, 0, 1, 1);
        checks++; if (drop_count_o !== 2'd0 || overrun_count_o !== 2'd0) begin
            errors++; $display("FAIL sat_clear got %0d/%0d exp 0/0", drop_count_o, overrun_count_o); end
        idle(1);
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(5) == 0), 8'($urandom), $urandom_range(1), ($urandom_range(7) != 0),
                 ($urandom_range(31) == 0));
            checks++; if (rx_reading_o !== m_ack) begin errors++; $display("FAIL rnd_reading got %b exp %b", rx_reading_o, m_ack); end
            checks++; if (fifo_count_o !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_count got %0d exp %0d", fifo_count_o, m_q.size()); end
            checks++; if (out_valid_o !== (m_q.size() != 0) || out_data_o !== m_head()) begin
                errors++; $display("FAIL rnd_head got %b/%h exp %b/%h", out_valid_o, out_data_o, m_q.size() != 0, m_head()); end
            checks++; if (drop_count_o !== 2'(m_drop) || overrun_count_o !== 2'(m_ovr)) begin
                errors++; $display("FAIL rnd_counters got %0d/%0d exp %0d/%0d", drop_count_o, overrun_count_o, m_drop, m_ovr); end
        end
        idle(3);
        drain();
        step(0, 8'h00, 0, 1, 1);
    endtask

    task automatic test_reset_mid();
        step(1, 8'h31, 0, 1, 0); idle(2);
        step(1, 8'h32, 0, 1, 0); idle(2);
        step(1, 8'h33, 0, 1, 0);
        checks++; if (rx_reading_o !== 1'b1 || fifo_count_o !== 3'd3) begin
            errors++; $display("FAIL mid_pre got %b/%0d exp 1/3", rx_reading_o, fifo_count_o); end
        #2 reset_i = 1;
        #1;
        checks++; if (rx_reading_o !== 1'b0 || out_valid_o !== 1'b0 || fifo_count_o !== 3'd0) begin
            errors++; $display("FAIL mid_async got %b/%b/%0d exp 0/0/0", rx_reading_o, out_valid_o, fifo_count_o); end
        checks++; if (drop_count_o !== '0 || overrun_count_o !== '0) begin
            errors++; $display("FAIL mid_counters got %0d/%0d exp 0/0", drop_count_o, overrun_count_o); end
        m_q.delete(); m_drop = 0; m_ovr = 0; m_ack = 0;
        rx_ready_i = 0; rx_overrun_i = 0;
        @(negedge clock_i); reset_i = 0;
        step(1, 8'h5A, 0, 1, 0);
        idle(2);
        checks++; if (fifo_count_o !== 3'd1 || out_data_o !== 8'h5A) begin
            errors++; $display("FAIL mid_after got %0d/%h exp 1/5a", fifo_count_o, out_data_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drop();
        test_full_pop();
        test_enable();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
